// File: rtl/alu_pkg.sv
// Shared unit select codes and sequencer FSM state encoding for the ALU
// controller slice.
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational unit decode: unit code to one-hot enable {SHIFT,CMP,Logic,Arith},
// plus a mux that selects that unit's {OUT, Flag} pair.
module alu_func_decode
  import alu_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic [1:0]       i_unit,
  input  logic [Width-1:0] i_arith_out,
  input  logic [Width-1:0] i_logic_out,
  input  logic [Width-1:0] i_cmp_out,
  input  logic [Width-1:0] i_shift_out,
  input  logic             i_arith_flag,
  input  logic             i_logic_flag,
  input  logic             i_cmp_flag,
  input  logic             i_shift_flag,
  output logic [3:0]       o_enable,
  output logic [Width-1:0] o_out,
  output logic             o_flag
);

  always_comb begin
    o_enable = 4'b0000;
    o_out    = '0;
    o_flag   = 1'b0;
    case (i_unit)
      UNIT_ARITH: begin o_enable = 4'b0001; o_out = i_arith_out; o_flag = i_arith_flag; end
      UNIT_LOGIC: begin o_enable = 4'b0010; o_out = i_logic_out; o_flag = i_logic_flag; end
      UNIT_CMP:   begin o_enable = 4'b0100; o_out = i_cmp_out;   o_flag = i_cmp_flag;   end
      UNIT_SHIFT: begin o_enable = 4'b1000; o_out = i_shift_out; o_flag = i_shift_flag; end
      default:    begin o_enable = 4'b0000; o_out = '0;          o_flag = 1'b0;         end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-to-ALU-unit sequencer: accept, issue one enable pulse, wait for the
// selected unit's flag (or time out), then hold the response until taken.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int Width   = 16,
  parameter int TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [Width-1:0] cmd_a,
  input  logic [Width-1:0] cmd_b,
  input  logic [3:0]       cmd_func,
  output logic [Width-1:0] A,
  output logic [Width-1:0] B,
  output logic [1:0]       ALU_FUNC,
  output logic             Arith_Enable,
  output logic             Logic_Enable,
  output logic             CMP_Enable,
  output logic             SHIFT_Enable,
  input  logic [Width-1:0] Arith_OUT,
  input  logic [Width-1:0] Logic_OUT,
  input  logic [Width-1:0] CMP_OUT,
  input  logic [Width-1:0] SHIFT_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Width-1:0] rsp_data,
  output logic             rsp_err
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CNT_LIM = CntW'(TIMEOUT);

  state_t           r_state;
  logic             r_cmd_ready;
  logic [Width-1:0] r_a;
  logic [Width-1:0] r_b;
  logic [1:0]       r_func;
  logic [1:0]       r_unit;
  logic [3:0]       r_enable;
  logic [CntW-1:0]  r_cnt;
  logic             r_rsp_valid;
  logic [Width-1:0] r_rsp_data;
  logic             r_rsp_err;

  logic [1:0]       w_unit;
  logic [3:0]       w_enable;
  logic [Width-1:0] w_out;
  logic             w_flag;
  logic [CntW-1:0]  w_cnt_nxt;

  // Enables are decoded from the incoming command; flags from the latched one.
  assign w_unit    = (r_state == IDLE) ? cmd_func[3:2] : r_unit;
  assign w_cnt_nxt = (r_cnt == CNT_LIM) ? r_cnt : r_cnt + 1'b1;

  alu_func_decode #(.Width(Width)) u_decode (
    .i_unit       (w_unit),
    .i_arith_out  (Arith_OUT),
    .i_logic_out  (Logic_OUT),
    .i_cmp_out    (CMP_OUT),
    .i_shift_out  (SHIFT_OUT),
    .i_arith_flag (Arith_Flag),
    .i_logic_flag (Logic_Flag),
    .i_cmp_flag   (CMP_Flag),
    .i_shift_flag (SHIFT_Flag),
    .o_enable     (w_enable),
    .o_out        (w_out),
    .o_flag       (w_flag)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_func      <= 2'b00;
      r_unit      <= 2'b00;
      r_enable    <= 4'b0000;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_cmd_ready) begin
            r_cmd_ready <= 1'b1;
          end else if (cmd_valid) begin
            r_a         <= cmd_a;
            r_b         <= cmd_b;
            r_func      <= cmd_func[1:0];
            r_unit      <= cmd_func[3:2];
            r_enable    <= w_enable;
            r_cmd_ready <= 1'b0;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_enable <= 4'b0000;
          r_state  <= WAIT;
        end
        WAIT: begin
          if (w_flag) begin
            r_rsp_data  <= w_out;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_LIM) begin
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign A            = r_a;
  assign B            = r_b;
  assign ALU_FUNC     = r_func;
  assign Arith_Enable = r_enable[0];
  assign Logic_Enable = r_enable[1];
  assign CMP_Enable   = r_enable[2];
  assign SHIFT_Enable = r_enable[3];
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with simple registered unit models.
module tb_alu_op_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [3:0]  cmd_func;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUNC;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
  logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic        logic_flag_q;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;

  logic [3:0]  alive;
  logic        force_logic;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  alu_op_sequencer #(.Width(16), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
    .A(A), .B(B), .ALU_FUNC(ALU_FUNC),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
    .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Unit models: result and flag appear the cycle after the unit's enable.
  assign Logic_Flag = logic_flag_q | force_logic;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Arith_Flag <= 1'b0; logic_flag_q <= 1'b0; CMP_Flag <= 1'b0; SHIFT_Flag <= 1'b0;
      Arith_OUT <= '0; Logic_OUT <= '0; CMP_OUT <= '0; SHIFT_OUT <= '0;
    end else begin
      Arith_Flag   <= Arith_Enable & alive[0];
      logic_flag_q <= Logic_Enable & alive[1];
      CMP_Flag     <= CMP_Enable   & alive[2];
      SHIFT_Flag   <= SHIFT_Enable & alive[3];
      if (Arith_Enable) Arith_OUT <= (ALU_FUNC == 2'b01) ? A - B : A + B;
      if (Logic_Enable)
        case (ALU_FUNC)
          2'b00:   Logic_OUT <= A & B;
          2'b01:   Logic_OUT <= A | B;
          2'b10:   Logic_OUT <= A ^ B;
          default: Logic_OUT <= ~A;
        endcase
      if (CMP_Enable)
        CMP_OUT <= (ALU_FUNC == 2'b00) ? {15'd0, A == B} : {15'd0, A > B};
      if (SHIFT_Enable)
        SHIFT_OUT <= (ALU_FUNC == 2'b00) ? A >> 1 : (ALU_FUNC == 2'b01) ? A << 1 : A;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  func;
    logic [3:0]  alive;
    logic        force_logic;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];
  int   last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; leaves in the cycle rsp_valid rises.
  task automatic run_cmd(input vec_t v, input string tag);
    int n;
    int lat;
    alive = v.alive; force_logic = v.force_logic;
    cmd_a = v.a; cmd_b = v.b; cmd_func = v.func; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge CLK); n++; end
    if (!cmd_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    last_acc = cyc;
    cmd_valid = 1'b0;
    check({tag, "_enable"}, {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable},
          32'd1 << v.func[3:2]);
    check({tag, "_alu_func"}, ALU_FUNC, v.func[1:0]);
    check({tag, "_a"}, A, v.a);
    check({tag, "_b"}, B, v.b);
    @(negedge CLK);
    check({tag, "_enable_off"}, {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 0);
    lat = 2;
    while (!rsp_valid && lat < 20) begin @(negedge CLK); lat++; end
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_data"}, rsp_data, v.exp_data);
    check({tag, "_err"}, rsp_err, v.exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_acc;
    int bb[4];
    int nv;
    vec_t v;

    vecs[0] = '{16'hF0F0, 16'h0FF0, 4'b0100, 4'hF, 1'b0, 16'h00F0, 1'b0, 3};
    vecs[1] = '{16'h1234, 16'h0F0F, 4'b0000, 4'hF, 1'b0, 16'h2143, 1'b0, 3};
    vecs[2] = '{16'h1000, 16'h0001, 4'b0001, 4'hF, 1'b0, 16'h0FFF, 1'b0, 3};
    vecs[3] = '{16'hF0F0, 16'h0FF0, 4'b0101, 4'hF, 1'b0, 16'hFFF0, 1'b0, 3};
    vecs[4] = '{16'hF0F0, 16'h0FF0, 4'b0110, 4'hF, 1'b0, 16'hFF00, 1'b0, 3};
    vecs[5] = '{16'h00AA, 16'h00AA, 4'b1000, 4'hF, 1'b0, 16'h0001, 1'b0, 3};
    vecs[6] = '{16'h00AA, 16'h00AB, 4'b1000, 4'hF, 1'b0, 16'h0000, 1'b0, 3};
    vecs[7] = '{16'h8001, 16'h0000, 4'b1100, 4'hF, 1'b0, 16'h4000, 1'b0, 3};
    vecs[8] = '{16'h8001, 16'h0000, 4'b1101, 4'hF, 1'b0, 16'h0002, 1'b0, 3};
    // CMP never answers while Logic's flag is stuck high: must time out.
    vecs[9] = '{16'hABCD, 16'h1111, 4'b1001, 4'b1011, 1'b1, 16'h0000, 1'b1, 6};

    // Reset with a command already waiting.
    RST = 1'b1; rsp_ready = 1'b1; alive = 4'hF; force_logic = 1'b0;
    cmd_a = 16'hF0F0; cmd_b = 16'h0FF0; cmd_func = 4'b0100; cmd_valid = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_enables", {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable}, 0);
    check("rst_a_b", {A, B}, 0);
    check("rst_alu_func", ALU_FUNC, 0);
    check("rst_rsp", {rsp_data, rsp_err}, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("rel_cmd_ready", cmd_ready, 1);
    check("rel_no_issue_yet", Logic_Enable, 0);
    @(negedge CLK);
    check("rel_accept_issue", Logic_Enable, 1);
    cmd_valid = 1'b0;
    nv = 0;
    while (!rsp_valid && nv < 20) begin @(negedge CLK); nv++; end
    check("rel_rsp_data", rsp_data, 16'h00F0);
    @(negedge CLK);
    check("rel_back_idle", cmd_ready, 1);

    // Table sweep, including the timeout vector.
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
      @(negedge CLK);
      check($sformatf("vec%0d_rsp_done", i), rsp_valid, 0);
      check($sformatf("vec%0d_ready_back", i), cmd_ready, 1);
    end
    force_logic = 1'b0;

    // Back-to-back, one command per unit, responses taken immediately.
    bb[0] = 1; bb[1] = 0; bb[2] = 5; bb[3] = 7;
    prev_acc = 0;
    for (int u = 0; u < 4; u++) begin
      run_cmd(vecs[bb[u]], $sformatf("b2b%0d", u));
      if (u > 0) check($sformatf("b2b%0d_spacing", u), last_acc - prev_acc, 4);
      prev_acc = last_acc;
    end
    @(negedge CLK);

    // Backpressure: response must hold while rsp_ready is low.
    rsp_ready = 1'b0;
    run_cmd(vecs[3], "bp");
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("bp_hold_valid%0d", k), rsp_valid, 1);
      check($sformatf("bp_hold_data%0d", k), rsp_data, 16'hFFF0);
      check($sformatf("bp_cmd_ready%0d", k), cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_ready", cmd_ready, 1);

    // Reset during WAIT aborts the command with no response.
    v = vecs[5];
    alive = 4'b1011;
    cmd_a = v.a; cmd_b = v.b; cmd_func = v.func; cmd_valid = 1'b1;
    nv = 0;
    while (!cmd_ready && nv < 20) begin @(negedge CLK); nv++; end
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_a_b", {A, B}, 0);
    check("mid_rst_ready_valid", {cmd_ready, rsp_valid}, 0);
    check("mid_rst_alu_func", ALU_FUNC, 0);
    @(negedge CLK);
    RST = 1'b0;
    alive = 4'hF;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (rsp_valid) nv++;
    end
    check("mid_rst_no_rsp", nv, 0);
    check("mid_rst_ready_after", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
